// File: rtl/de0_trigger_rx_pkg.sv
// de0_trigger_pkg: shared state encoding, width constants and helpers for the DE0 trigger receiver
package de0_trigger_pkg;
  typedef enum logic [2:0] {DISARMED, ARMED, MEASURE, HOLDOFF, WAIT_LOW} state_t;
  localparam int WIDTH_W = 8;
  function automatic int hold_w(input int holdoff);
    return $clog2(holdoff + 1);
  endfunction
endpackage

// File: rtl/de0_trigger_rx_if.sv
// de0_trigger_rx_if: trigger line, arm control and receiver status bundle
interface de0_trigger_rx_if import de0_trigger_pkg::*; #(parameter int CNT_W = 16) ();
  logic trigger_in;
  logic arm;
  logic armed;
  logic trig_event;
  logic pulse_err;
  logic [CNT_W-1:0] trig_count;
  logic [WIDTH_W-1:0] last_width;
  modport master(output trigger_in, arm, input armed, trig_event, pulse_err, trig_count, last_width);
  modport slave(input trigger_in, arm, output armed, trig_event, pulse_err, trig_count, last_width);
endinterface

// File: rtl/de0_trigger_rx_trig_sync.sv
// trig_sync: multi-flop synchroniser for an asynchronous input, plus a one-cycle delayed copy for edge detection
module trig_sync #(parameter int STAGES = 2) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic sync,
  output logic prev_sync
);
  logic [STAGES:0] s_q, s_d;
  always_comb s_d = {s_q[STAGES-1:0], d};
  always_ff @(posedge clk or posedge rst)
    if (rst) s_q <= '0;
    else s_q <= s_d;
  assign sync = s_q[STAGES-1];
  assign prev_sync = s_q[STAGES];
endmodule

// File: rtl/de0_trigger_rx.sv
// de0_trigger_rx: accepts DE0 trigger pulses inside a width window, counts them and enforces a holdoff
module de0_trigger_rx
  import de0_trigger_pkg::state_t, de0_trigger_pkg::DISARMED, de0_trigger_pkg::ARMED,
         de0_trigger_pkg::MEASURE, de0_trigger_pkg::WAIT_LOW, de0_trigger_pkg::WIDTH_W,
         de0_trigger_pkg::hold_w;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WIDTH = 20,
  parameter int MAX_WIDTH = 30,
  parameter int HOLDOFF = 25000000,
  parameter int CNT_W = 16
) (
  input logic int_clock,
  input logic reset,
  de0_trigger_rx_if.slave bus
);
  localparam int HW = hold_w(HOLDOFF);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);
  localparam logic [WIDTH_W-1:0] MINW = WIDTH_W'(MIN_WIDTH);
  localparam logic [WIDTH_W-1:0] MAXW = WIDTH_W'(MAX_WIDTH);
  if (SYNC_STAGES < 2 || MIN_WIDTH > MAX_WIDTH || MAX_WIDTH >= 255 || HOLDOFF < 1) begin : g_bad_params
    $error("de0_trigger_rx: invalid parameters");
  end
  logic sync, prev_sync, rise;
  trig_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(int_clock), .rst(reset), .d(bus.trigger_in), .sync(sync), .prev_sync(prev_sync)
  );
  assign rise = sync & ~prev_sync;
  state_t state_q, state_d;
  logic [WIDTH_W-1:0] width_q, width_d, lw_q, lw_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ev_q, ev_d, err_q, err_d, armed_q, armed_d;
  // The HOLDOFF state literal is shadowed by the parameter of the same name, so it is package-qualified
  always_comb begin
    state_d = state_q;
    width_d = width_q;
    lw_d = lw_q;
    hold_d = hold_q;
    cnt_d = cnt_q;
    ev_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      DISARMED: if (bus.arm && !sync) state_d = ARMED;
      ARMED:
        if (rise) begin
          state_d = MEASURE;
          width_d = WIDTH_W'(1);
        end else if (!bus.arm) state_d = DISARMED;
      MEASURE:
        if (sync) begin
          if (width_q == MAXW) begin
            err_d = 1'b1;
            lw_d = MAXW + WIDTH_W'(1);
            state_d = WAIT_LOW;
          end else width_d = width_q + WIDTH_W'(1);
        end else if (width_q >= MINW) begin
          ev_d = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          lw_d = width_q;
          hold_d = '0;
          state_d = de0_trigger_pkg::HOLDOFF;
        end else begin
          err_d = 1'b1;
          lw_d = width_q;
          state_d = bus.arm ? ARMED : DISARMED;
        end
      de0_trigger_pkg::HOLDOFF:
        if (hold_q == HOLD_LAST) state_d = sync ? WAIT_LOW : bus.arm ? ARMED : DISARMED;
        else hold_d = hold_q + HW'(1);
      WAIT_LOW: if (!sync) state_d = bus.arm ? ARMED : DISARMED;
      default: state_d = DISARMED;
    endcase
    armed_d = state_d == ARMED;
  end
  always_ff @(posedge int_clock or posedge reset)
    if (reset) begin
      state_q <= DISARMED;
      width_q <= '0;
      lw_q <= '0;
      hold_q <= '0;
      cnt_q <= '0;
      ev_q <= 1'b0;
      err_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      width_q <= width_d;
      lw_q <= lw_d;
      hold_q <= hold_d;
      cnt_q <= cnt_d;
      ev_q <= ev_d;
      err_q <= err_d;
      armed_q <= armed_d;
    end
  assign bus.armed = armed_q;
  assign bus.trig_event = ev_q;
  assign bus.pulse_err = err_q;
  assign bus.trig_count = cnt_q;
  assign bus.last_width = lw_q;
endmodule

// File: tb/tb_de0_trigger_rx.sv
// tb_de0_trigger_rx: directed width-window vectors plus hand sequences for latency, holdoff, arming and reset
module tb_de0_trigger_rx;
  logic int_clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int ev_n = 0;
  int err_n = 0;
  int exp_cnt = 0;
  de0_trigger_rx_if #(.CNT_W(16)) bus ();
  de0_trigger_rx #(.SYNC_STAGES(2), .MIN_WIDTH(20), .MAX_WIDTH(30), .HOLDOFF(100), .CNT_W(16)) dut (
    .int_clock(int_clock), .reset(reset), .bus(bus.slave)
  );
  always #5 int_clock = ~int_clock;
  typedef struct {int width; int ev; int err; int lw;} vec_t;
  vec_t vecs[9];
  always @(negedge int_clock) begin
    ev_n <= ev_n + int'(bus.trig_event);
    err_n <= err_n + int'(bus.pulse_err);
    if (bus.trig_event && bus.pulse_err) begin
      errors++;
      $display("FAIL exclusive: trig_event=1 and pulse_err=1 together, required not both");
    end
  end
  task automatic tick();
    @(posedge int_clock);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic pulse(input int w);
    bus.trigger_in = 1'b1;
    repeat (w) tick();
    bus.trigger_in = 1'b0;
  endtask
  initial begin
    int e0, r0;
    vecs[0] = '{25, 1, 0, 25};
    vecs[1] = '{5, 0, 1, 5};
    vecs[2] = '{20, 1, 0, 20};
    vecs[3] = '{19, 0, 1, 19};
    vecs[4] = '{30, 1, 0, 30};
    vecs[5] = '{31, 0, 1, 31};
    vecs[6] = '{200, 0, 1, 31};
    vecs[7] = '{1, 0, 1, 1};
    vecs[8] = '{21, 1, 0, 21};
    bus.trigger_in = 1'b0;
    bus.arm = 1'b0;
    repeat (3) tick();
    chk("rst_armed", int'(bus.armed), 0);
    chk("rst_event", int'(bus.trig_event), 0);
    chk("rst_err", int'(bus.pulse_err), 0);
    chk("rst_count", int'(bus.trig_count), 0);
    chk("rst_width", int'(bus.last_width), 0);
    reset = 1'b0;
    tick();
    chk("disarmed", int'(bus.armed), 0);
    bus.arm = 1'b1;
    repeat (4) tick();
    chk("armed_up", int'(bus.armed), 1);
    e0 = ev_n;
    r0 = err_n;
    pulse(25);
    repeat (2) tick();
    chk("lat_early", int'(bus.trig_event), 0);
    tick();
    chk("lat_event", int'(bus.trig_event), 1);
    chk("lat_width", int'(bus.last_width), 25);
    chk("lat_count", int'(bus.trig_count), 1);
    tick();
    chk("lat_single", int'(bus.trig_event), 0);
    exp_cnt = 1;
    repeat (120) tick();
    chk("lat_evn", ev_n - e0, 1);
    chk("lat_errn", err_n - r0, 0);
    for (int i = 0; i < 9; i++) begin
      e0 = ev_n;
      r0 = err_n;
      pulse(vecs[i].width);
      repeat (130) tick();
      exp_cnt += vecs[i].ev;
      chk($sformatf("v%0d_event", i), ev_n - e0, vecs[i].ev);
      chk($sformatf("v%0d_err", i), err_n - r0, vecs[i].err);
      chk($sformatf("v%0d_width", i), int'(bus.last_width), vecs[i].lw);
      chk($sformatf("v%0d_count", i), int'(bus.trig_count), exp_cnt);
      chk($sformatf("v%0d_armed", i), int'(bus.armed), 1);
    end
    e0 = ev_n;
    r0 = err_n;
    pulse(200);
    repeat (4) tick();
    chk("stuck_rearm", int'(bus.armed), 1);
    chk("stuck_err", err_n - r0, 1);
    chk("stuck_width", int'(bus.last_width), 31);
    e0 = ev_n;
    pulse(25);
    repeat (25) tick();
    pulse(25);
    repeat (225) tick();
    chk("hold_one", ev_n - e0, 1);
    pulse(25);
    repeat (10) tick();
    exp_cnt += 2;
    chk("hold_second", ev_n - e0, 2);
    chk("hold_count", int'(bus.trig_count), exp_cnt);
    repeat (120) tick();
    e0 = ev_n;
    r0 = err_n;
    pulse(25);
    repeat (84) tick();
    bus.trigger_in = 1'b1;
    repeat (20) tick();
    chk("hold_waitlow", int'(bus.armed), 0);
    repeat (20) tick();
    bus.trigger_in = 1'b0;
    repeat (4) tick();
    chk("hold_exit_armed", int'(bus.armed), 1);
    chk("hold_exit_ev", ev_n - e0, 1);
    chk("hold_exit_err", err_n - r0, 0);
    exp_cnt += 1;
    e0 = ev_n;
    r0 = err_n;
    bus.trigger_in = 1'b1;
    repeat (2) tick();
    bus.arm = 1'b0;
    repeat (23) tick();
    bus.trigger_in = 1'b0;
    repeat (120) tick();
    exp_cnt += 1;
    chk("prio_event", ev_n - e0, 1);
    chk("prio_count", int'(bus.trig_count), exp_cnt);
    chk("prio_disarmed", int'(bus.armed), 0);
    e0 = ev_n;
    r0 = err_n;
    bus.trigger_in = 1'b1;
    repeat (10) tick();
    bus.arm = 1'b1;
    repeat (10) tick();
    chk("armhigh_wait", int'(bus.armed), 0);
    bus.trigger_in = 1'b0;
    repeat (4) tick();
    chk("armhigh_armed", int'(bus.armed), 1);
    chk("armhigh_ev", ev_n - e0, 0);
    chk("armhigh_err", err_n - r0, 0);
    e0 = ev_n;
    r0 = err_n;
    bus.trigger_in = 1'b1;
    repeat (12) tick();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_armed", int'(bus.armed), 0);
    chk("mid_rst_count", int'(bus.trig_count), 0);
    chk("mid_rst_width", int'(bus.last_width), 0);
    chk("mid_rst_event", int'(bus.trig_event), 0);
    chk("mid_rst_err", int'(bus.pulse_err), 0);
    tick();
    bus.trigger_in = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (4) tick();
    pulse(25);
    repeat (10) tick();
    chk("post_rst_count", int'(bus.trig_count), 1);
    chk("post_rst_ev", ev_n - e0, 1);
    chk("post_rst_err", err_n - r0, 0);
    chk("post_rst_width", int'(bus.last_width), 25);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
